uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmitter between two byte producers: the processor core's output port and the loader's echo (loop-back) path. Each requester pushes into its own small FIFO. A round-robin scheduler drains the FIFOs one byte at a time, handshaking with the slow-domain transmitter through `start_transmit`/`tx_ready`. It sits between `brainfuckCore`/loader and the `clockCatcher` → `uart` path and replaces the static loading mux on the TX side.

## Interface

**Parameters**
- `fifoAddrSize`, default 2: log2 of the per-requester FIFO depth (4 entries).
- `busyTimeout`, default 255: number of sysClk cycles to wait for `tx_ready` to fall after a start before abandoning the byte.

**Ports**
- `sysClk`, input, 1: main clock.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `push_core`, input, 1: one-cycle strobe; `data_core` enqueued into FIFO 0.
- `data_core`, input, 8: core output byte.
- `push_echo`, input, 1: one-cycle strobe; `data_echo` enqueued into FIFO 1.
- `data_echo`, input, 8: loop-back byte.
- `tx_ready`, input, 1: transmitter idle (uartEn domain, level, slow).
- `start_transmit`, output, 1: one-cycle start pulse toward `clockCatcher`.
- `data_tx`, output, 8: byte to send; stable from the pulse until return to IDLE.
- `full_core`, `full_echo`, output, 1 each: FIFO full (backpressure).
- `overflow_core`, `overflow_echo`, output, 1 each: sticky, set when a push hits a full FIFO.
- `timeout_err`, output, 1: one-cycle pulse when a byte is abandoned.
- `busy`, output, 1: scheduler not in IDLE.

## Operation

**FIFOs**
- Each FIFO holds 2^`fifoAddrSize` entries; pointers are `fifoAddrSize`+1 bits wide with a wrap bit.
- Push when full: the data is dropped and the sticky overflow flag is set. The exception is a push and a pop of the same FIFO in the same cycle, which is accepted.
- Pop only occurs on the IDLE→ISSUE transition.

**Scheduler states**
- IDLE: if `tx_ready`=1 and any FIFO is non-empty, grant one requester, load `data_tx` from its head, pop it, and go to ISSUE.
- ISSUE: `start_transmit`=1 for exactly this cycle, then go to WAIT_BUSY.
- WAIT_BUSY: wait for `tx_ready`=0, then go to WAIT_READY. If the cycle counter reaches `busyTimeout`, pulse `timeout_err` and go to IDLE; the byte is lost.
- WAIT_READY: wait for `tx_ready`=1, then go to IDLE. There is no timeout in this state.

**Arbitration**
- A 1-bit `last_grant` register resets to 1 (echo), so core wins the first tie.
- When both FIFOs are non-empty, grant the requester that is not `last_grant`. Otherwise grant the only non-empty one.
- `last_grant` updates on each grant.

**Reset values**
- `start_transmit`=0, `data_tx`=0, `busy`=0, `timeout_err`=0.
- Both overflow flags = 0.
- FIFOs empty, so `full_*`=0.
- State = IDLE.

## Timing

- A push sampled at edge N makes the FIFO non-empty after N.
- The IDLE grant occurs at edge N+1, and `start_transmit` is high during cycle N+2. Push-to-start latency is 2 cycles when idle.
- `data_tx` is valid in the same cycle as `start_transmit` and holds until the next grant.
- The WAIT_BUSY counter starts at 0 on ISSUE→WAIT_BUSY and increments each cycle. The timeout fires at edge `busyTimeout`.
- Back-to-back bytes have a minimum spacing of 1 + busy latency + transmit time + 1 cycles. No new start is issued while `tx_ready`=0.
- Reset asserted mid-transfer returns to IDLE asynchronously and drops `start_transmit` immediately. Bytes already handed to the UART are not recalled.
- `full_*` and overflow flags update on the edge after the offending push.

## Structure

- Shared package `uart_pkg` holds:
  - state encoding constants: IDLE=0, ISSUE=1, WAIT_BUSY=2, WAIT_READY=3;
  - requester IDs: CORE=0, ECHO=1.
- Sub-module `byteFifo` (parameter `addrSize`; ports: push, data in, pop, head out, empty, full, overflow) is instantiated twice.
- Arbiter and scheduler FSM live in the top module.

## Test plan

- **Single core byte:** push_core 0x41 in idle with `tx_ready`=1.
  - `start_transmit` pulses 2 cycles later with `data_tx`=0x41.
  - No second pulse until `tx_ready` falls then rises.
- **Simultaneous pushes:** core 0x11 and echo 0x22 in the same cycle.
  - Output order is 0x11 then 0x22.
  - Next tie (0x33 core / 0x44 echo) yields 0x33, then 0x44.
- **Overflow:** hold `tx_ready`=0 and push 5 echo bytes 0x01..0x05.
  - `full_echo`=1 after the 4th push; `overflow_echo`=1 after the 5th.
  - After release, output is 0x01..0x04 only.
- **Timeout:** `tx_ready` stays 1 after a start.
  - `timeout_err` pulses 255 cycles after ISSUE; state returns to IDLE.
  - The next queued byte is issued.
- **Push and pop on full:** FIFO full, and a push occurs in the same cycle as the grant.
  - No overflow is flagged; the new byte is sent last.
- **Async reset:** assert `reset` in WAIT_READY with 3 bytes queued.
  - `busy`, `start_transmit`, and the flags clear immediately, and FIFOs are empty.
  - With `tx_ready`=1 after release, no start pulse occurs.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbiter: scheduler states, requester IDs
// and the round-robin pick helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_BUSY  = 2'd2,
    WAIT_READY = 2'd3
  } sched_state_e;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_ECHO = 1'b1;

  // Round-robin pick between two requesters: on a tie the one that did not
  // win last time goes; otherwise whichever has data. Result is only
  // meaningful when at least one requester is valid.
  function automatic logic pick_requester(input logic core_vld,
                                          input logic echo_vld,
                                          input logic last_grant);
    logic pick;
    if (core_vld && echo_vld) begin
      pick = ~last_grant;
    end else if (echo_vld) begin
      pick = REQ_ECHO;
    end else begin
      pick = REQ_CORE;
    end
    return pick;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_fifo.sv
// byteFifo: small byte FIFO with a sticky overflow flag, one per TX requester.
// Latency: a push is visible at head/empty on the edge after it is sampled.
// Backpressure: full is exported; a push into a full FIFO is dropped and sets
//   overflow, unless a pop of the same FIFO happens in that cycle.
// Ports: clk, rst (async active-high), push/din (enqueue), pop (dequeue head),
//   head (oldest byte), empty, full, overflow (sticky until reset).
module byteFifo
  import uart_pkg::*;
#(
  parameter int addrSize = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  input  logic              pop,
  output logic [BYTE_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam int DEPTH = 1 << addrSize;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [addrSize:0]   wr_ptr_q, wr_ptr_d;
  logic [addrSize:0]   rd_ptr_q, rd_ptr_d;
  logic                ovf_q, ovf_d;
  logic [BYTE_W-1:0]   mem_q [DEPTH];
  logic                do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[addrSize] != rd_ptr_q[addrSize]) &&
                 (wr_ptr_q[addrSize-1:0] == rd_ptr_q[addrSize-1:0]);

  assign do_pop  = pop && !empty;
  // A slot freed by a same-cycle pop makes room for the incoming byte.
  assign do_push = push && (!full || do_pop);

  assign head     = mem_q[rd_ptr_q[addrSize-1:0]];
  assign overflow = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !do_push) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: head is only consumed when the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[addrSize-1:0]] <= din;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between the core output port
//   and the loader echo path via two byteFifos and a round-robin scheduler.
// Latency: push-to-start_transmit is 2 cycles when idle with tx_ready high.
// Backpressure: full_core/full_echo per requester; pushes into a full FIFO are
//   dropped and flagged in the sticky overflow_core/overflow_echo.
// Ports: sysClk, reset (async active-high); push_*/data_* byte producers;
//   tx_ready (transmitter idle level), start_transmit/data_tx toward the
//   transmitter; full_*, overflow_*, timeout_err (abandon pulse), busy.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int fifoAddrSize = 2,
  parameter int busyTimeout  = 255
) (
  input  logic       sysClk,
  input  logic       reset,
  input  logic       push_core,
  input  logic [7:0] data_core,
  input  logic       push_echo,
  input  logic [7:0] data_echo,
  input  logic       tx_ready,
  output logic       start_transmit,
  output logic [7:0] data_tx,
  output logic       full_core,
  output logic       full_echo,
  output logic       overflow_core,
  output logic       overflow_echo,
  output logic       timeout_err,
  output logic       busy
);

  localparam int               CNT_W        = (busyTimeout > 1) ? $clog2(busyTimeout) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(busyTimeout - 1);

  logic             core_empty, echo_empty;
  logic [7:0]       core_head, echo_head;
  logic             pop_core, pop_echo;
  logic             grant_vld;
  logic             grant_id;

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic [7:0]       data_q, data_d;

  byteFifo #(.addrSize(fifoAddrSize)) u_fifo_core (
    .clk      (sysClk),
    .rst      (reset),
    .push     (push_core),
    .din      (data_core),
    .pop      (pop_core),
    .head     (core_head),
    .empty    (core_empty),
    .full     (full_core),
    .overflow (overflow_core)
  );

  byteFifo #(.addrSize(fifoAddrSize)) u_fifo_echo (
    .clk      (sysClk),
    .rst      (reset),
    .push     (push_echo),
    .din      (data_echo),
    .pop      (pop_echo),
    .head     (echo_head),
    .empty    (echo_empty),
    .full     (full_echo),
    .overflow (overflow_echo)
  );

  assign grant_id = pick_requester(!core_empty, !echo_empty, last_grant_q);
  assign pop_core = grant_vld && (grant_id == REQ_CORE);
  assign pop_echo = grant_vld && (grant_id == REQ_ECHO);

  assign data_tx = data_q;
  assign busy    = (state_q != IDLE);

  // tx_ready is assumed already brought into the sysClk domain upstream; it
  // is only used as a level here.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_grant_d   = last_grant_q;
    data_d         = data_q;
    grant_vld      = 1'b0;
    start_transmit = 1'b0;
    timeout_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_ready && (!core_empty || !echo_empty)) begin
          grant_vld    = 1'b1;
          last_grant_d = grant_id;
          data_d       = (grant_id == REQ_ECHO) ? echo_head : core_head;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        start_transmit = 1'b1;
        cnt_d          = '0;
        state_d        = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A falling tx_ready wins over a timeout landing on the same edge.
        // timeout_err is high in the last WAIT_BUSY cycle, so it coincides
        // with the edge where the counter would reach busyTimeout.
        if (!tx_ready) begin
          state_d = WAIT_READY;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_err = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_READY: begin
        if (tx_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= REQ_ECHO;  // core wins the first tie after reset
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  logic       sysClk = 1'b0;
  logic       reset;
  logic       push_core, push_echo;
  logic [7:0] data_core, data_echo;
  logic       tx_ready;
  logic       start_transmit, full_core, full_echo;
  logic       overflow_core, overflow_echo, timeout_err, busy;
  logic [7:0] data_tx;

  // Transmitter stand-in: tx_rdy_int is its own idle level, hold_low lets the
  // bench keep the line busy so pushes pile up before any grant.
  logic hold_low, ignore_start, tx_rdy_int;
  int   busy_lat, tx_time;
  assign tx_ready = ~hold_low & tx_rdy_int;

  int checks = 0, failures = 0;

  always #5 sysClk = ~sysClk;

  uart_tx_arbiter dut (
    .sysClk(sysClk), .reset(reset),
    .push_core(push_core), .data_core(data_core),
    .push_echo(push_echo), .data_echo(data_echo),
    .tx_ready(tx_ready), .start_transmit(start_transmit), .data_tx(data_tx),
    .full_core(full_core), .full_echo(full_echo),
    .overflow_core(overflow_core), .overflow_echo(overflow_echo),
    .timeout_err(timeout_err), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: two bounded queues + round robin ----
  localparam int CAP = 4;
  logic [7:0] m_q0[$], m_q1[$], exp_q[$];
  bit m_last, m_ovf0, m_ovf1;

  function automatic void m_reset();
    m_q0.delete(); m_q1.delete(); exp_q.delete();
    m_last = 1'b1; m_ovf0 = 1'b0; m_ovf1 = 1'b0;
  endfunction

  function automatic void m_push(input bit req, input logic [7:0] d);
    if (req == 1'b0) begin
      if (m_q0.size() < CAP) m_q0.push_back(d); else m_ovf0 = 1'b1;
    end else begin
      if (m_q1.size() < CAP) m_q1.push_back(d); else m_ovf1 = 1'b1;
    end
  endfunction

  function automatic void m_grant();
    bit pick;
    if (m_q0.size() == 0 && m_q1.size() == 0) return;
    if (m_q0.size() != 0 && m_q1.size() != 0) pick = !m_last;
    else pick = (m_q0.size() == 0);
    m_last = pick;
    if (pick == 1'b0) exp_q.push_back(m_q0.pop_front());
    else              exp_q.push_back(m_q1.pop_front());
  endfunction

  function automatic void m_drain();
    while (m_q0.size() != 0 || m_q1.size() != 0) m_grant();
  endfunction

  // ---------------- transmitter responder ----------------
  initial begin
    tx_rdy_int = 1'b1;
    forever begin
      @(posedge sysClk); #1;
      if (start_transmit === 1'b1 && !ignore_start) begin
        repeat (busy_lat) @(posedge sysClk);
        #1 tx_rdy_int = 1'b0;
        repeat (tx_time) @(posedge sysClk);
        #1 tx_rdy_int = 1'b1;
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [7:0] got_q[$];
  int   bad_start = 0, dbl_start = 0;
  logic edge_rdy = 1'b1, prev_start = 1'b0;

  always @(posedge sysClk) edge_rdy = tx_ready;  // level seen by the grant edge

  always @(negedge sysClk) begin
    if (start_transmit === 1'b1) begin
      got_q.push_back(data_tx);
      if (edge_rdy !== 1'b1)   bad_start++;
      if (prev_start === 1'b1) dbl_start++;
    end
    prev_start = start_transmit;
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge sysClk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    m_reset();
    got_q.delete();
    step(1);
  endtask

  task automatic wait_drain(input string tag);
    int quiet;
    int t;
    logic [31:0] g;
    quiet = 0;
    t = 0;
    while (quiet < 6 && t < 3000) begin
      @(negedge sysClk);
      t++;
      if (busy === 1'b0 && tx_ready === 1'b1 && got_q.size() >= exp_q.size()) quiet++;
      else quiet = 0;
    end
    chk($sformatf("%s_drain_in_time", tag), 32'(t < 3000), 32'd1);
    chk($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hxxxxxxxx;
      chk($sformatf("%s_byte%0d", tag, i), g, {24'd0, exp_q[i]});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- directed + randomized sequence ----------------
  initial begin
    int n;
    int ncyc;
    reset = 1'b1; push_core = 1'b0; push_echo = 1'b0;
    data_core = 8'h00; data_echo = 8'h00;
    hold_low = 1'b0; ignore_start = 1'b0; busy_lat = 2; tx_time = 4;
    m_reset();
    step(3);
    chk("rst_start", start_transmit, 0);
    chk("rst_data_tx", data_tx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_full_core", full_core, 0);
    chk("rst_full_echo", full_echo, 0);
    chk("rst_ovf_core", overflow_core, 0);
    chk("rst_ovf_echo", overflow_echo, 0);
    reset = 1'b0;
    step(1);

    // Single core byte: start two cycles after the push.
    push_core = 1'b1; data_core = 8'h41; m_push(0, 8'h41);
    step(1);
    push_core = 1'b0;
    chk("t1_no_early_start", start_transmit, 0);
    step(1);
    chk("t1_start", start_transmit, 1);
    chk("t1_data", data_tx, 8'h41);
    chk("t1_busy", busy, 1);
    step(1);
    chk("t1_one_cycle", start_transmit, 0);
    m_drain();
    wait_drain("t1");
    chk("t1_data_hold", data_tx, 8'h41);

    // Simultaneous pushes after reset: core wins first tie.
    do_reset();
    push_core = 1'b1; data_core = 8'h11; push_echo = 1'b1; data_echo = 8'h22;
    m_push(0, 8'h11); m_push(1, 8'h22);
    step(1);
    push_core = 1'b0; push_echo = 1'b0;
    m_drain();
    wait_drain("t2a");
    push_core = 1'b1; data_core = 8'h33; push_echo = 1'b1; data_echo = 8'h44;
    m_push(0, 8'h33); m_push(1, 8'h44);
    step(1);
    push_core = 1'b0; push_echo = 1'b0;
    m_drain();
    wait_drain("t2b");

    // Overflow on the echo FIFO while the transmitter is held busy.
    hold_low = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      push_echo = 1'b1; data_echo = 8'(i); m_push(1, 8'(i));
      step(1);
      push_echo = 1'b0;
      chk($sformatf("t3_full_after_%0d", i), full_echo, 32'(i >= 4));
      chk($sformatf("t3_ovf_after_%0d", i), overflow_echo, 32'(i >= 5));
    end
    hold_low = 1'b0;
    m_drain();
    wait_drain("t3");
    chk("t3_ovf_sticky", overflow_echo, 1);
    chk("t3_ovf_core_clear", overflow_core, 0);

    // Push into a full FIFO on the same edge as its pop: accepted.
    do_reset();
    hold_low = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_echo = 1'b1; data_echo = 8'h50 + 8'(i); m_push(1, 8'h50 + 8'(i));
      step(1);
      push_echo = 1'b0;
    end
    chk("t4_full_before", full_echo, 1);
    hold_low = 1'b0;
    push_echo = 1'b1; data_echo = 8'h54;
    m_grant(); m_push(1, 8'h54);
    step(1);
    push_echo = 1'b0;
    chk("t4_no_ovf", overflow_echo, 0);
    chk("t4_still_full", full_echo, 1);
    m_drain();
    wait_drain("t4");

    // Timeout: transmitter never reacts to the first start.
    hold_low = 1'b1;
    push_core = 1'b1; data_core = 8'hA1; m_push(0, 8'hA1);
    step(1);
    data_core = 8'hA2; m_push(0, 8'hA2);
    step(1);
    push_core = 1'b0;
    ignore_start = 1'b1;
    hold_low = 1'b0;
    n = 0;
    do begin step(1); n++; end while (start_transmit !== 1'b1 && n < 20);
    chk("t5_first_start", start_transmit, 1);
    chk("t5_first_data", data_tx, 8'hA1);
    n = 0;
    do begin step(1); n++; end while (timeout_err !== 1'b1 && n < 400);
    chk("t5_timeout_delay", n, 255);
    step(1);
    chk("t5_timeout_pulse_end", timeout_err, 0);
    chk("t5_back_idle", busy, 0);
    ignore_start = 1'b0;
    step(1);
    chk("t5_next_start", start_transmit, 1);
    chk("t5_next_data", data_tx, 8'hA2);
    m_drain();
    wait_drain("t5");

    // Async reset while waiting for the transmitter, 3 bytes queued.
    busy_lat = 1; tx_time = 30;
    hold_low = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_core = 1'b1; data_core = 8'hB0 + 8'(i);
      step(1);
    end
    push_core = 1'b0;
    hold_low = 1'b0;
    n = 0;
    do begin step(1); n++; end while (tx_ready !== 1'b0 && n < 20);
    step(2);
    chk("t6_busy_before", busy, 1);
    chk("t6_ovf_before", overflow_core, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_busy_async", busy, 0);
    chk("t6_start_async", start_transmit, 0);
    chk("t6_data_async", data_tx, 0);
    chk("t6_ovf_async", overflow_core, 0);
    chk("t6_full_async", full_core, 0);
    step(1);
    reset = 1'b0;
    m_reset();
    got_q.delete();
    n = 0;
    do begin step(1); n++; end while (tx_ready !== 1'b1 && n < 60);
    step(40);
    chk("t6_no_start_after", got_q.size(), 0);
    chk("t6_idle_after", busy, 0);

    // Randomized batches: fill under hold, release, compare order and flags.
    for (int r = 0; r < 10; r++) begin
      busy_lat = $urandom_range(1, 4);
      tx_time  = $urandom_range(1, 8);
      ncyc     = $urandom_range(1, 7);
      hold_low = 1'b1;
      for (int c = 0; c < ncyc; c++) begin
        push_core = 1'($urandom_range(0, 1));
        push_echo = 1'($urandom_range(0, 1));
        data_core = 8'($urandom_range(0, 255));
        data_echo = 8'($urandom_range(0, 255));
        if (push_core) m_push(0, data_core);
        if (push_echo) m_push(1, data_echo);
        step(1);
        push_core = 1'b0; push_echo = 1'b0;
      end
      chk($sformatf("r%0d_full_core", r), full_core, 32'(m_q0.size() == CAP));
      chk($sformatf("r%0d_full_echo", r), full_echo, 32'(m_q1.size() == CAP));
      chk($sformatf("r%0d_ovf_core", r), overflow_core, 32'(m_ovf0));
      chk($sformatf("r%0d_ovf_echo", r), overflow_echo, 32'(m_ovf1));
      hold_low = 1'b0;
      m_drain();
      wait_drain($sformatf("r%0d", r));
    end

    chk("start_while_busy", bad_start, 0);
    chk("multi_cycle_start", dbl_start, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
